sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge_if.sv | 81 ++++++++
 rtl/sram_axi_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_if.sv
// Bundles the SRAM-like inst/data ports and the AXI3 master channels of sram_axi_bridge.
// master is the bridge view; slave is the CPU + AXI memory view.
interface sram_axi_bridge_if;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// SRAM-like inst/data ports to a single-beat AXI3 master; independent read and write FSMs.
// Optional macro SRAM_AXI_BRIDGE_RAW_CHECK_EN: stall data reads that hit the pending write word.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID   = 4'd0,
  parameter logic [3:0] DATA_ID   = 4'd1,
  parameter logic [3:0] AXI_CACHE = 4'b0000
) (
  input logic               clk,
  input logic               resetn,
  sram_axi_bridge_if.master bus
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_B = 2'd2} w_state_e;

  function automatic logic [3:0] wstrb_f(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << off;
      2'd1:    strb = off[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [2:0]  ar_size_q, ar_size_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [2:0]  aw_size_q, aw_size_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        inst_ok_q, data_ok_q, wr_ok_pend_q;

  logic raw_block_s, data_rd_acc_s, inst_rd_acc_s, data_wr_acc_s;
  logic r_hs_s, b_hs_s, r_inst_s;
  logic unused_s;

`ifdef SRAM_AXI_BRIDGE_RAW_CHECK_EN
  assign raw_block_s = (w_state_q != W_IDLE) && (bus.data_addr[31:2] == aw_addr_q[31:2]);
`else
  assign raw_block_s = 1'b0;
`endif

  assign data_rd_acc_s = bus.data_req && !bus.data_wr && (r_state_q == R_IDLE) && !raw_block_s;
  assign inst_rd_acc_s = bus.inst_req && (r_state_q == R_IDLE) && !data_rd_acc_s;
  assign data_wr_acc_s = bus.data_req && bus.data_wr && (w_state_q == W_IDLE);
  assign r_hs_s        = (r_state_q == R_R) && bus.rvalid;
  assign b_hs_s        = (w_state_q == W_B) && bus.bvalid;
  assign r_inst_s      = (bus.rid == INST_ID);

  // Read FSM next state and AR payload capture
  always_comb begin
    r_state_d = r_state_q;
    ar_id_d   = ar_id_q;
    ar_addr_d = ar_addr_q;
    ar_size_d = ar_size_q;
    case (r_state_q)
      R_IDLE: begin
        if (data_rd_acc_s) begin
          ar_id_d   = DATA_ID;
          ar_addr_d = bus.data_addr;
          ar_size_d = {1'b0, bus.data_size};
          r_state_d = R_AR;
        end else if (inst_rd_acc_s) begin
          ar_id_d   = INST_ID;
          ar_addr_d = bus.inst_addr;
          ar_size_d = {1'b0, bus.inst_size};
          r_state_d = R_AR;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_AR:    r_state_d = bus.arready ? R_R : R_AR;
      R_R:     r_state_d = bus.rvalid ? R_IDLE : R_R;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM: AW and W valids retire independently, B waits for both
  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    aw_size_d = aw_size_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    case (w_state_q)
      W_IDLE: begin
        if (data_wr_acc_s) begin
          aw_addr_d = bus.data_addr;
          aw_size_d = {1'b0, bus.data_size};
          w_data_d  = bus.data_wdata;
          w_strb_d  = wstrb_f(bus.data_size, bus.data_addr[1:0]);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          w_state_d = W_AW;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_AW: begin
        if (awvalid_q && bus.awready) awvalid_d = 1'b0;
        else                          awvalid_d = awvalid_q;
        if (wvalid_q && bus.wready)   wvalid_d = 1'b0;
        else                          wvalid_d = wvalid_q;
        if (!awvalid_d && !wvalid_d)  w_state_d = W_B;
        else                          w_state_d = W_AW;
      end
      W_B:     w_state_d = bus.bvalid ? W_IDLE : W_B;
      default: w_state_d = W_IDLE;
    endcase
  end

  // State and channel payload registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      ar_id_q   <= 4'd0;
      ar_addr_q <= 32'd0;
      ar_size_q <= 3'd0;
      aw_addr_q <= 32'd0;
      aw_size_q <= 3'd0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      ar_id_q   <= ar_id_d;
      ar_addr_q <= ar_addr_d;
      ar_size_q <= ar_size_d;
      aw_addr_q <= aw_addr_d;
      aw_size_q <= aw_size_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end

  // Response side: a write ack coinciding with a read completion is pushed back one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      wr_ok_pend_q <= 1'b0;
    end else begin
      inst_rdata_q <= (r_hs_s && r_inst_s)  ? bus.rdata : inst_rdata_q;
      data_rdata_q <= (r_hs_s && !r_inst_s) ? bus.rdata : data_rdata_q;
      inst_ok_q    <= r_hs_s && r_inst_s;
      data_ok_q    <= (r_hs_s && !r_inst_s) || (b_hs_s && !r_hs_s) || wr_ok_pend_q;
      wr_ok_pend_q <= b_hs_s && r_hs_s;
    end
  end

  assign bus.inst_addr_ok = resetn && inst_rd_acc_s;
  assign bus.data_addr_ok = resetn && (data_rd_acc_s || data_wr_acc_s);
  assign bus.inst_data_ok = inst_ok_q;
  assign bus.data_data_ok = data_ok_q;
  assign bus.inst_rdata   = inst_rdata_q;
  assign bus.data_rdata   = data_rdata_q;

  assign bus.arid    = ar_id_q;
  assign bus.araddr  = ar_addr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = ar_size_q;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = AXI_CACHE;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = (r_state_q == R_AR);
  assign bus.rready  = (r_state_q == R_R);

  assign bus.awid    = DATA_ID;
  assign bus.awaddr  = aw_addr_q;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = aw_size_q;
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = AXI_CACHE;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = awvalid_q;
  assign bus.wid     = DATA_ID;
  assign bus.wdata   = w_data_q;
  assign bus.wstrb   = w_strb_q;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = (w_state_q == W_B);

  assign unused_s = ^{bus.inst_wr, bus.inst_wdata, bus.rresp, bus.rlast, bus.bid, bus.bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: vector table for single transactions plus hand sequences.
module tb_sram_axi_bridge;
  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  sram_axi_bridge_if bus ();

  sram_axi_bridge #(
    .INST_ID  (4'd0),
    .DATA_ID  (4'd1),
    .AXI_CACHE(4'b0011)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic        port_inst;
    logic        inst_wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_id;
    logic [2:0]  exp_size;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.inst_size = 2'd0;
    bus.inst_addr = 32'd0; bus.inst_wdata = 32'd0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'd0;
    bus.data_addr = 32'd0; bus.data_wdata = 32'd0;
    bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata = 32'd0; bus.rresp = 2'd0;
    bus.rlast = 1'b1; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bid = 4'd0; bus.bresp = 2'd0; bus.bvalid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_wr) begin
      bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = v.size;
      bus.data_addr = v.addr; bus.data_wdata = v.wdata;
      #1 chk("vec_wr_addr_ok", bus.data_addr_ok, 32'd1);
      step();
      bus.data_req = 1'b0; bus.data_wr = 1'b0;
      chk("vec_awvalid", bus.awvalid, 32'd1);
      chk("vec_wvalid", bus.wvalid, 32'd1);
      chk("vec_awid", bus.awid, v.exp_id);
      chk("vec_awaddr", bus.awaddr, v.addr);
      chk("vec_awsize", bus.awsize, v.exp_size);
      chk("vec_wstrb", bus.wstrb, v.exp_strb);
      chk("vec_wdata", bus.wdata, v.wdata);
      bus.awready = 1'b1; bus.wready = 1'b1;
      step();
      bus.awready = 1'b0; bus.wready = 1'b0;
      chk("vec_bready", bus.bready, 32'd1);
      bus.bvalid = 1'b1;
      step();
      bus.bvalid = 1'b0;
      chk("vec_wr_data_ok", bus.data_data_ok, 32'd1);
      step();
      chk("vec_wr_data_ok_drop", bus.data_data_ok, 32'd0);
    end else begin
      if (v.port_inst) begin
        bus.inst_req = 1'b1; bus.inst_wr = v.inst_wr; bus.inst_size = v.size; bus.inst_addr = v.addr;
        #1 chk("vec_inst_addr_ok", bus.inst_addr_ok, 32'd1);
      end else begin
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = v.size; bus.data_addr = v.addr;
        #1 chk("vec_data_addr_ok", bus.data_addr_ok, 32'd1);
      end
      step();
      bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.data_req = 1'b0;
      chk("vec_arvalid", bus.arvalid, 32'd1);
      chk("vec_arid", bus.arid, v.exp_id);
      chk("vec_araddr", bus.araddr, v.addr);
      chk("vec_arsize", bus.arsize, v.exp_size);
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0;
      chk("vec_rready", bus.rready, 32'd1);
      bus.rvalid = 1'b1; bus.rid = v.exp_id; bus.rdata = v.wdata;
      step();
      bus.rvalid = 1'b0;
      chk("vec_inst_data_ok", bus.inst_data_ok, {31'd0, v.port_inst});
      chk("vec_data_data_ok", bus.data_data_ok, {31'd0, !v.port_inst});
      chk("vec_rdata", v.port_inst ? bus.inst_rdata : bus.data_rdata, v.wdata);
      step();
      chk("vec_rd_ok_drop", bus.inst_data_ok | bus.data_data_ok, 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0013, 32'h0000_00AB, 4'd1, 3'd0, 4'b1000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0022, 32'h0000_1234, 4'd1, 3'd1, 4'b1100};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0020, 32'h0000_5678, 4'd1, 3'd1, 4'b0011};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'h89AB_CDEF, 4'd1, 3'd2, 4'b1111};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_0011, 4'd1, 3'd0, 4'b0001};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 4'd0, 3'd2, 4'b0000};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_2001, 32'h0000_0055, 4'd1, 3'd0, 4'b0000};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_3000, 32'h1357_9BDF, 4'd0, 3'd1, 4'b0000};

    idle_inputs();
    resetn = 1'b0;
    bus.data_req = 1'b1;
    #1;
    chk("rst_data_addr_ok", bus.data_addr_ok, 32'd0);
    chk("rst_arvalid", bus.arvalid, 32'd0);
    chk("rst_awvalid", bus.awvalid, 32'd0);
    chk("rst_wvalid", bus.wvalid, 32'd0);
    chk("rst_rready", bus.rready, 32'd0);
    chk("rst_bready", bus.bready, 32'd0);
    chk("rst_data_ok", bus.inst_data_ok | bus.data_data_ok, 32'd0);
    bus.data_req = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();
    chk("const_arcache", bus.arcache, 32'h3);
    chk("const_awcache", bus.awcache, 32'h3);
    chk("const_arlen", bus.arlen, 32'd0);
    chk("const_awburst", bus.awburst, 32'd1);
    chk("const_wlast", bus.wlast, 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Simultaneous inst and data reads: data wins, inst waits for the R handshake
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1000; bus.inst_size = 2'd2;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h2000; bus.data_size = 2'd2;
    #1 chk("pri_data_addr_ok", bus.data_addr_ok, 32'd1);
    chk("pri_inst_addr_ok", bus.inst_addr_ok, 32'd0);
    step();
    bus.data_req = 1'b0;
    chk("pri_arid_data", bus.arid, 32'd1);
    chk("pri_araddr_data", bus.araddr, 32'h2000);
    chk("pri_inst_blocked_ar", bus.inst_addr_ok, 32'd0);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    chk("pri_inst_blocked_r", bus.inst_addr_ok, 32'd0);
    bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'hA5A5_0001;
    step();
    bus.rvalid = 1'b0;
    chk("pri_data_ok", bus.data_data_ok, 32'd1);
    chk("pri_inst_addr_ok_late", bus.inst_addr_ok, 32'd1);
    step();
    bus.inst_req = 1'b0;
    chk("pri_arid_inst", bus.arid, 32'd0);
    chk("pri_araddr_inst", bus.araddr, 32'h1000);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'hA5A5_0002;
    step();
    bus.rvalid = 1'b0;
    chk("pri_inst_ok", bus.inst_data_ok, 32'd1);
    chk("pri_inst_rdata", bus.inst_rdata, 32'hA5A5_0002);
    step();

    // Data write and inst read accepted in the same cycle
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h40; bus.data_size = 2'd2;
    bus.data_wdata = 32'h0000_0040;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h80; bus.inst_size = 2'd2;
    #1 chk("dual_data_addr_ok", bus.data_addr_ok, 32'd1);
    chk("dual_inst_addr_ok", bus.inst_addr_ok, 32'd1);
    step();
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.inst_req = 1'b0;
    chk("dual_arvalid", bus.arvalid, 32'd1);
    chk("dual_awvalid", bus.awvalid, 32'd1);
    chk("dual_wvalid", bus.wvalid, 32'd1);
    chk("dual_araddr", bus.araddr, 32'h80);
    bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
    step();
    bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b1;
    step();
    bus.bvalid = 1'b0;
    chk("dual_wr_ok", bus.data_data_ok, 32'd1);
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h0000_0080;
    step();
    bus.rvalid = 1'b0;
    chk("dual_inst_ok", bus.inst_data_ok, 32'd1);
    chk("dual_no_data_ok", bus.data_data_ok, 32'd0);
    step();

    // Data read and write responses in the same cycle: two separate data_ok pulses
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h200; bus.data_size = 2'd2;
    step();
    bus.data_wr = 1'b0; bus.data_addr = 32'h300;
    bus.awready = 1'b1; bus.wready = 1'b1;
    #1 chk("merge_rd_addr_ok", bus.data_addr_ok, 32'd1);
    step();
    bus.data_req = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    chk("merge_arvalid", bus.arvalid, 32'd1);
    chk("merge_bready", bus.bready, 32'd1);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'hCAFE_0001; bus.bvalid = 1'b1;
    step();
    bus.rvalid = 1'b0; bus.bvalid = 1'b0;
    chk("merge_ok_rd", bus.data_data_ok, 32'd1);
    chk("merge_rdata", bus.data_rdata, 32'hCAFE_0001);
    step();
    chk("merge_ok_wr", bus.data_data_ok, 32'd1);
    step();
    chk("merge_ok_drop", bus.data_data_ok, 32'd0);

    // awready late, wready immediate
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h44; bus.data_size = 2'd2;
    step();
    bus.data_req = 1'b0; bus.data_wr = 1'b0;
    bus.wready = 1'b1;
    step();
    bus.wready = 1'b0;
    chk("late_wvalid_drop", bus.wvalid, 32'd0);
    chk("late_awvalid_hold0", bus.awvalid, 32'd1);
    chk("late_bready0", bus.bready, 32'd0);
    step();
    chk("late_awvalid_hold1", bus.awvalid, 32'd1);
    chk("late_bready1", bus.bready, 32'd0);
    step();
    chk("late_awvalid_hold2", bus.awvalid, 32'd1);
    bus.awready = 1'b1;
    step();
    bus.awready = 1'b0;
    chk("late_awvalid_drop", bus.awvalid, 32'd0);
    chk("late_bready", bus.bready, 32'd1);
    bus.bvalid = 1'b1;
    step();
    bus.bvalid = 1'b0;
    chk("late_wr_ok", bus.data_data_ok, 32'd1);
    step();

    // Read to the word of a pending write
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h100; bus.data_size = 2'd2;
    step();
    bus.data_wr = 1'b0; bus.data_addr = 32'h102; bus.data_size = 2'd1;
`ifdef SRAM_AXI_BRIDGE_RAW_CHECK_EN
    #1 chk("raw_block_aw", bus.data_addr_ok, 32'd0);
    bus.awready = 1'b1; bus.wready = 1'b1;
    step();
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b1;
    #1 chk("raw_block_b", bus.data_addr_ok, 32'd0);
    step();
    bus.bvalid = 1'b0;
    #1 chk("raw_release", bus.data_addr_ok, 32'd1);
    step();
    bus.data_req = 1'b0;
`else
    #1 chk("raw_accept", bus.data_addr_ok, 32'd1);
    step();
    bus.data_req = 1'b0;
    bus.awready = 1'b1; bus.wready = 1'b1;
    step();
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b1;
    step();
    bus.bvalid = 1'b0;
    chk("raw_wr_ok", bus.data_data_ok, 32'd1);
`endif
    chk("raw_araddr", bus.araddr, 32'h102);
    chk("raw_arvalid", bus.arvalid, 32'd1);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h0000_0102;
    step();
    bus.rvalid = 1'b0;
    chk("raw_rd_ok", bus.data_data_ok, 32'd1);
    step();

    // Reset in the middle of a read data phase
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h500; bus.data_size = 2'd2;
    step();
    bus.data_req = 1'b0;
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    chk("mid_rready", bus.rready, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_rready", bus.rready, 32'd0);
    chk("mid_rst_arvalid", bus.arvalid, 32'd0);
    chk("mid_rst_data_ok", bus.data_data_ok, 32'd0);
    chk("mid_rst_data_rdata", bus.data_rdata, 32'd0);
    chk("mid_rst_inst_rdata", bus.inst_rdata, 32'd0);
    bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h0000_0500;
    step(); step();
    resetn = 1'b1;
    step();
    bus.rvalid = 1'b0;
    chk("mid_post_rready", bus.rready, 32'd0);
    chk("mid_post_data_ok0", bus.data_data_ok, 32'd0);
    step();
    chk("mid_post_data_ok1", bus.data_data_ok, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
